wb_reg_bank: RTL
================

WB_REG_BANK -- requirements
Module: wb_reg_bank

Interface
REQ-001 Parameter NREGS, default 4: number of 32-bit registers; legal range 1..16.
REQ-002 Parameter ADDR_W, default 4: word-address width; 2**ADDR_W SHALL be at least NREGS.
REQ-003 Parameter RESET_VAL, default all zeros: NREGS*32 bits; register k resets to RESET_VAL[32k+31:32k].
REQ-004 Parameter RO_MASK, default all zeros: NREGS bits; bit k set makes register k read-only.
REQ-005 Parameter WR_PIPE, default 1: 0 or 1 extra write-path pipeline stages.
REQ-006 Parameter RD_PIPE, default 1: 0 or 1 extra read-path pipeline stages.
REQ-007 clk_i  in  1  single clock, rising edge.
REQ-008 rst_n_i  in  1  asynchronous, active-low reset.
REQ-009 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic-pipelined control.
REQ-010 wb_adr_i  in  ADDR_W  word address.
REQ-011 wb_sel_i  in  4  byte selects.
REQ-012 wb_dat_i  in  32  write data.
REQ-013 wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o  out  1 each  Wishbone responses.
REQ-014 wb_dat_o  out  32  read data.
REQ-015 regs_o  out  NREGS*32  current value of each RW register.
REQ-016 regs_i  in  NREGS*32  read value of each read-only register.
REQ-017 wr_o  out  NREGS  one-cycle write strobe per register.

Function
REQ-018 A request SHALL be accepted in cycle T when wb_cyc_i&wb_stb_i is high and no transaction is outstanding; at most one transaction SHALL be outstanding.
REQ-019 wb_stall_o SHALL equal wb_cyc_i&wb_stb_i&~(wb_ack_o|wb_err_o).
REQ-020 A write accepted in T SHALL update the addressed RW register at the clock edge ending cycle T+WR_PIPE.
REQ-021 For a write accepted in T, wb_ack_o and wr_o[addr] SHALL be high for exactly one cycle, T+1+WR_PIPE.
REQ-022 A write SHALL update only the bytes whose wb_sel_i bit was set in T; a write with wb_sel_i=0 SHALL still ack and pulse wr_o.
REQ-023 A write to a RO_MASK register SHALL ack and pulse wr_o but SHALL NOT change any state.
REQ-024 A read accepted in T SHALL assert wb_ack_o for one cycle, T+1+RD_PIPE.
REQ-025 wb_dat_o SHALL be valid in the ack cycle and SHALL return the value sampled in T: the register value for RW registers, regs_i slice for RO registers.
REQ-026 An address >= NREGS SHALL give wb_err_o instead of wb_ack_o, with the same latency, no state change, no wr_o pulse, and wb_dat_o=0.
REQ-027 wb_rty_o SHALL be constant 0.
REQ-028 wb_ack_o and wb_err_o SHALL never be high together.
REQ-029 If wb_cyc_i drops while a transaction is outstanding, the response SHALL still be issued, and the next request SHALL NOT be accepted before that response cycle.
REQ-030 A request presented in a response cycle SHALL be accepted in the following cycle (back-to-back accesses).

Reset
REQ-031 rst_n_i low SHALL immediately clear wb_ack_o, wb_err_o, wr_o, wb_dat_o and all pipeline state, and load RESET_VAL into regs_o.
REQ-032 Reset asserted mid-transaction SHALL abort it: no response is issued and no register is updated after reset asserts.
REQ-033 The first request SHALL be accepted no earlier than the first rising edge after rst_n_i deasserts.

Verification
REQ-034 Reset, then read all registers, NREGS=4, RESET_VAL word 2=0xCAFE0001 -> read addr 2 returns 0xCAFE0001, ack at T+2 with RD_PIPE=1.
REQ-035 Write 0x11223344 to addr 1 with sel=0101 over 0x00000000 -> addr 1 reads 0x00220044; wr_o[1] pulses once, at T+2 with WR_PIPE=1.
REQ-036 Write to addr 7 with NREGS=4 -> wb_err_o one cycle, no ack, no wr_o pulse; a following read of addr 7 returns err with wb_dat_o=0.
REQ-037 RO_MASK bit 3 set, regs_i word 3=0xA5A5A5A5, write 0xFFFFFFFF to addr 3 -> ack and wr_o[3] pulse; read returns 0xA5A5A5A5.
REQ-038 Back-to-back write then read of addr 0 for each WR_PIPE/RD_PIPE combination -> read returns the new data; ack latencies as in REQ-021/REQ-024; stall high until each ack.
REQ-039 rst_n_i pulsed low in the cycle after a write is accepted -> no ack, regs_o equals RESET_VAL afterwards.

Source files
------------

// File: rtl/wb_reg_bank.sv
// Wishbone classic-pipelined register bank: NREGS 32-bit registers with byte
// enables, optional read-only slots and independently pipelined write/read paths.
module wb_reg_bank #(
  parameter int                   NREGS     = 4,
  parameter int                   ADDR_W    = 4,
  parameter logic [NREGS*32-1:0]  RESET_VAL = '0,
  parameter logic [NREGS-1:0]     RO_MASK   = '0,
  parameter int                   WR_PIPE   = 1,
  parameter int                   RD_PIPE   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_W-1:0]     wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic                  wb_stall_o,
  output logic [31:0]           wb_dat_o,
  output logic [NREGS*32-1:0]   regs_o,
  input  logic [NREGS*32-1:0]   regs_i,
  output logic [NREGS-1:0]      wr_o
);

  localparam bit WP = (WR_PIPE != 0);
  localparam bit RP = (RD_PIPE != 0);

  function automatic logic bad_adr(input logic [ADDR_W-1:0] a);
    return ({{(32-ADDR_W){1'b0}}, a} >= 32'(NREGS));
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return r;
  endfunction

  logic                 busy;
  logic                 acc;
  logic [NREGS*32-1:0]  regs_q;
  logic [31:0]          rd_now;

  logic                 vld_p0;
  logic                 we_p0;
  logic [ADDR_W-1:0]    adr_p0;
  logic [3:0]           sel_p0;
  logic [31:0]          dat_p0;
  logic [31:0]          rdat_p0;

  logic                 wr_go;
  logic [ADDR_W-1:0]    wr_adr;
  logic [3:0]           wr_sel;
  logic [31:0]          wr_dat;
  logic                 wr_bad;
  logic [NREGS-1:0]     wr_hit;
  logic                 rd_go;
  logic [ADDR_W-1:0]    rd_adr;
  logic [31:0]          rd_dat;
  logic                 rd_bad;

  // The outstanding flag covers the accept cycle through the response cycle,
  // so a request held during the response is only taken one cycle later.
  assign acc        = wb_cyc_i & wb_stb_i & ~busy;
  assign wb_stall_o = wb_cyc_i & wb_stb_i & ~(wb_ack_o | wb_err_o);
  assign wb_rty_o   = 1'b0;
  assign regs_o     = regs_q;

  always_comb begin
    rd_now = '0;
    for (int k = 0; k < NREGS; k++)
      if (wb_adr_i == ADDR_W'(k))
        rd_now = RO_MASK[k] ? regs_i[32*k +: 32] : regs_q[32*k +: 32];
  end

  // Stage p0: captured at the end of the accept cycle, used only by the
  // access type whose path is pipelined.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p0  <= 1'b0;
      we_p0   <= 1'b0;
      adr_p0  <= '0;
      sel_p0  <= '0;
      dat_p0  <= '0;
      rdat_p0 <= '0;
    end else begin
      vld_p0 <= acc & (wb_we_i ? WP : RP);
      if (acc) begin
        we_p0   <= wb_we_i;
        adr_p0  <= wb_adr_i;
        sel_p0  <= wb_sel_i;
        dat_p0  <= wb_dat_i;
        rdat_p0 <= rd_now;
      end
    end
  end

  always_comb begin
    wr_go  = WP ? (vld_p0 & we_p0) : (acc & wb_we_i);
    wr_adr = WP ? adr_p0 : wb_adr_i;
    wr_sel = WP ? sel_p0 : wb_sel_i;
    wr_dat = WP ? dat_p0 : wb_dat_i;
    rd_go  = RP ? (vld_p0 & ~we_p0) : (acc & ~wb_we_i);
    rd_adr = RP ? adr_p0 : wb_adr_i;
    rd_dat = RP ? rdat_p0 : rd_now;
    wr_bad = bad_adr(wr_adr);
    rd_bad = bad_adr(rd_adr);
    wr_hit = '0;
    for (int k = 0; k < NREGS; k++)
      wr_hit[k] = wr_go & (wr_adr == ADDR_W'(k));
  end

  // Response stage: ack/err, strobes and read data all registered together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy     <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      wr_o     <= '0;
    end else begin
      wb_ack_o <= (wr_go & ~wr_bad) | (rd_go & ~rd_bad);
      wb_err_o <= (wr_go & wr_bad) | (rd_go & rd_bad);
      wb_dat_o <= (rd_go & ~rd_bad) ? rd_dat : '0;
      wr_o     <= wr_hit;
      if (acc)
        busy <= 1'b1;
      else if (wb_ack_o | wb_err_o)
        busy <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      regs_q <= RESET_VAL;
    end else begin
      for (int k = 0; k < NREGS; k++)
        if (wr_hit[k] && !RO_MASK[k])
          regs_q[32*k +: 32] <= byte_merge(regs_q[32*k +: 32], wr_dat, wr_sel);
    end
  end

endmodule
